// File: rtl/dc1_wb_queue.sv
// dc1_wb_queue: writeback queue between the L1 tag/eviction path and L2.
// Victim line addresses are queued in a circular buffer and issued to L2 one at
// a time through a three-state output sequencer (IDLE -> REQ -> GAP).
// All state advances on the falling clock edge; rst is asynchronous, active-high.
// Optional build macro: DC1_WBQ_MERGE_EN drops pushes that duplicate a queued
// address (excluding the head currently being requested).
//
// Handshake: out_req is held high with a stable out_addr until out_ack is seen
// high at a falling edge while in REQ; that edge pops the head. out_ack outside
// REQ is ignored. Upstream must not push while full=1 (an attempted push then is
// dropped and latches err_ovf).
module dc1_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int AWIDTH = 37,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic              in_valid,
    output logic              full,
    output logic              out_req,
    output logic [AWIDTH-1:0] out_addr,
    input  logic              out_ack,
    output logic [CW-1:0]     count,
    output logic              err_ovf,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     cnt;
    logic              push_req;
    logic              pop;
    logic              dup;
    logic              do_push;
    logic              ovf_evt;

    assign push_req = in_en & in_valid;
    assign pop      = (state == ST_REQ) & out_ack;
    // A pop on the same edge frees a slot, so a full queue still accepts a push.
    assign full     = (cnt == DEPTH_C) & ~pop;
    assign do_push  = push_req & ~dup & ~full;
    assign ovf_evt  = push_req & ~dup & full;

`ifdef DC1_WBQ_MERGE_EN
    logic [PW-1:0] off;

    // Match in_addr against every occupied slot except a head already on the bus.
    always_comb begin
        dup = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (({1'b0, off} < cnt) && !((state == ST_REQ) && (PW'(i) == head))
                && (mem[i] == in_addr)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Entry storage: written at the tail on an accepted push, never reset.
    always_ff @(negedge clk) begin
        if (do_push) begin
            mem[tail] <= in_addr;
        end
    end

    // Pointers, occupancy, overflow flag and sequencer state.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            err_ovf <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            state <= state_nxt;
            if (do_push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({do_push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (ovf_evt) begin
                err_ovf <= 1'b1;
            end
        end
    end

    // Output sequencer: request the head, then one idle turnaround cycle.
    always_comb begin
        state_nxt = ST_IDLE;
        out_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cnt != '0) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                out_req   = 1'b1;
                state_nxt = out_ack ? ST_GAP : ST_REQ;
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_addr  = mem[head];
    assign count     = cnt;
    assign dbg_state = state;

endmodule

// File: tb/tb_dc1_wb_queue.sv
// Bench for dc1_wb_queue: table vectors, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_dc1_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 37;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_en = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic          in_valid = 1'b0;
    logic          full;
    logic          out_req;
    logic [AW-1:0] out_addr;
    logic          out_ack = 1'b0;
    logic [CW-1:0] count;
    logic          err_ovf;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    // reference model: ordered list of pending addresses plus output phase
    logic [AW-1:0] exp_q[$];
    int            m_phase;   // 0 idle, 1 requesting, 2 turnaround
    bit            m_ovf;

    dc1_wb_queue #(.DEPTH(DEPTH), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_addr(in_addr), .in_valid(in_valid),
        .full(full), .out_req(out_req), .out_addr(out_addr), .out_ack(out_ack),
        .count(count), .err_ovf(err_ovf), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_phase = 0;
        m_ovf   = 1'b0;
    endtask

    // one falling edge worth of queue behaviour, from the current inputs
    task automatic model_step();
        int sz;
        bit pop;
        bit dup;
        sz  = exp_q.size();
        pop = (m_phase == 1) && out_ack;
        dup = 1'b0;
`ifdef DC1_WBQ_MERGE_EN
        for (int i = 0; i < sz; i++) begin
            if (!(i == 0 && m_phase == 1) && exp_q[i] == in_addr) dup = 1'b1;
        end
`endif
        case (m_phase)
            0:       m_phase = (sz > 0) ? 1 : 0;
            1:       m_phase = out_ack ? 2 : 1;
            default: m_phase = 0;
        endcase
        if (pop) void'(exp_q.pop_front());
        if (in_en && in_valid && !dup) begin
            if (sz < DEPTH || pop) exp_q.push_back(in_addr);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_model();
        bit m_full;
        m_full = (exp_q.size() == DEPTH) && !((m_phase == 1) && out_ack);
        chk("out_req", out_req, (m_phase == 1));
        chk("count", count, exp_q.size());
        chk("full", full, m_full);
        chk("err_ovf", err_ovf, m_ovf);
        if (m_phase == 1 && exp_q.size() > 0) chk("out_addr", out_addr, exp_q[0]);
    endtask

    task automatic drive(input logic en, input logic v, input logic [AW-1:0] a, input logic ack);
        @(posedge clk);
        #1;
        in_en    = en;
        in_valid = v;
        in_addr  = a;
        out_ack  = ack;
        #1;
    endtask

    task automatic edge_step();
        @(negedge clk);
        model_step();
    endtask

    task automatic cycle(input logic en, input logic v, input logic [AW-1:0] a, input logic ack);
        drive(en, v, a, ack);
        check_model();
        edge_step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_en = 1'b0; in_valid = 1'b0; out_ack = 1'b0; in_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic          en;
        logic          valid;
        logic [AW-1:0] addr;
        logic          ack;
        logic          exp_req;
        logic [CW-1:0] exp_count;
        logic          exp_full;
        logic          exp_ovf;
        logic          chk_addr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t          vecs[19];
    logic [AW-1:0] pool[6];
    logic [AW-1:0] issued[$];
    logic [AW-1:0] a1, a2, a3, a4, a5;

    initial begin
        a1 = 37'h00_1000_0010; a2 = 37'h01_2345_6780; a3 = 37'h1F_FFFF_FFFE;
        a4 = 37'h00_0000_0001; a5 = 37'h0A_AAAA_AAAA;
        // fill with ack low, overflow, then drain in push order
        vecs[0]  = '{1'b0, 1'b0, '0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, '0};
        vecs[1]  = '{1'b1, 1'b1, a1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, '0};
        vecs[2]  = '{1'b1, 1'b1, a2, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, '0};
        vecs[3]  = '{1'b1, 1'b1, a3, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, a1};
        vecs[4]  = '{1'b1, 1'b1, a4, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, a1};
        vecs[5]  = '{1'b1, 1'b1, a5, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, a1};
        vecs[6]  = '{1'b1, 1'b0, a5, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, a1};
        vecs[7]  = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, a1};
        vecs[8]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, '0};
        vecs[9]  = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, '0};
        vecs[10] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, a2};
        vecs[11] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, '0};
        vecs[12] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, '0};
        vecs[13] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1, a3};
        vecs[14] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, '0};
        vecs[15] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, '0};
        vecs[16] = '{1'b0, 1'b0, '0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, a4};
        vecs[17] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, '0};
        vecs[18] = '{1'b0, 1'b0, '0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, '0};
        pool[0] = 37'h00_0000_0040; pool[1] = 37'h00_0000_0041; pool[2] = 37'h12_3456_7890;
        pool[3] = 37'h1F_0000_0000; pool[4] = 37'h00_FFFF_0001; pool[5] = 37'h05_5555_5555;

        model_clear();
        do_reset();

        // table vectors
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].en, vecs[i].valid, vecs[i].addr, vecs[i].ack);
            chk($sformatf("vec%0d_req", i), out_req, vecs[i].exp_req);
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
            chk($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
            chk($sformatf("vec%0d_ovf", i), err_ovf, vecs[i].exp_ovf);
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), out_addr, vecs[i].exp_addr);
            check_model();
            edge_step();
        end

        // single push with ack tied high: latency, pop and turnaround
        do_reset();
        chk("rst_req", out_req, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 1'b0);
        chk("rst_ovf", err_ovf, 1'b0);
        drive(1'b1, 1'b1, 37'h1_0000_0001, 1'b1);
        chk("lat_pre_count", count, 0);
        edge_step();
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("lat_n_count", count, 1);
        chk("lat_n_req", out_req, 1'b0);
        edge_step();
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("lat_n1_req", out_req, 1'b1);
        chk("lat_n1_addr", out_addr, 37'h1_0000_0001);
        edge_step();
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("gap_req", out_req, 1'b0);
        chk("gap_count", count, 0);
        edge_step();
        cycle(1'b0, 1'b0, '0, 1'b1);

        // push with in_valid low is ignored
        do_reset();
        cycle(1'b1, 1'b0, 37'h0_0000_0777, 1'b1);
        cycle(1'b1, 1'b0, 37'h0_0000_0777, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("novalid_count", count, 0);
        chk("novalid_req", out_req, 1'b0);
        edge_step();

        // push and pop on the same edge while holding DEPTH entries
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, pool[i], 1'b0);
        drive(1'b1, 1'b1, pool[5], 1'b1);
        chk("pp_full", full, 1'b0);
        chk("pp_req", out_req, 1'b1);
        check_model();
        edge_step();
        drive(1'b0, 1'b0, '0, 1'b1);
        chk("pp_count", count, 4);
        chk("pp_ovf", err_ovf, 1'b0);
        edge_step();
        issued.delete();
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            if (out_req) issued.push_back(out_addr);
            check_model();
            edge_step();
        end
        chk("pp_issued_n", issued.size(), 4);
        if (issued.size() == 4) begin
            chk("pp_order0", issued[0], pool[1]);
            chk("pp_order1", issued[1], pool[2]);
            chk("pp_order2", issued[2], pool[3]);
            chk("pp_order3", issued[3], pool[5]);
        end

        // duplicate address behind a stalled head
        do_reset();
        cycle(1'b1, 1'b1, pool[0], 1'b0);
        cycle(1'b1, 1'b1, pool[1], 1'b0);
        cycle(1'b1, 1'b1, pool[2], 1'b0);
        cycle(1'b1, 1'b1, pool[1], 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
`ifdef DC1_WBQ_MERGE_EN
        chk("dup_count", count, 3);
`else
        chk("dup_count", count, 4);
`endif
        chk("dup_ovf", err_ovf, 1'b0);
        edge_step();
        for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // asynchronous reset while a request is outstanding
        do_reset();
        cycle(1'b1, 1'b1, pool[4], 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
        chk("arst_pre_req", out_req, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req", out_req, 1'b0);
        chk("arst_count", count, 0);
        chk("arst_full", full, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // random traffic, first with mostly stalled ack, then mostly open
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  pool[$urandom_range(0, 5)], 1'($urandom_range(0, 9) < 2));
        end
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  pool[$urandom_range(0, 5)], 1'($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dc1_wb_queue.md
DC1_WB_QUEUE -- requirements
Module: dc1_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued writeback entries (power of 2, 2..8).
REQ-002 Parameter AWIDTH, default 37, line address width (PADDR_WIDTH-7, LSB is line-half select).
REQ-003 clk  in  1  single clock; all state updates on negedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_en  in  1  eviction slot written this cycle (tag way write_hit).
REQ-006 in_addr  in  AWIDTH  victim line address (tag way wb_addr).
REQ-007 in_valid  in  1  victim line was valid (tag way wb_valid); entry required only when 1.
REQ-008 full  out  1  queue cannot accept an entry this cycle; upstream stalls write_wen.
REQ-009 out_req  out  1  writeback request to L2, held until acknowledged.
REQ-010 out_addr  out  AWIDTH  address of head entry; stable while out_req=1.
REQ-011 out_ack  in  1  L2 accepted current request.
REQ-012 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 err_ovf  out  1  sticky: entry pushed while full and dropped.

Function
REQ-014 Push condition = in_en & in_valid; in_en with in_valid=0 is ignored, no state change.
REQ-015 Circular buffer with head/tail pointers wrapping modulo DEPTH; count = occupied entries, 0..DEPTH.
REQ-016 full = (count==DEPTH) & ~pop_this_cycle, combinational.
REQ-017 Push when count<DEPTH: write in_addr at tail, tail+1, count+1 at the edge.
REQ-018 Push and pop on the same edge: both happen, count unchanged, including at count==DEPTH.
REQ-019 Push when full and no pop: entry dropped, err_ovf set to 1, stays set until reset.
REQ-020 Output FSM states IDLE, REQ, GAP; encoded 2 bits; illegal encoding -> IDLE next edge.
REQ-021 IDLE: out_req=0; go to REQ at the edge where count>0 (count value before that edge's push).
REQ-022 REQ: out_req=1, out_addr=head entry; on out_ack=1 pop head (head+1, count-1) and go to GAP.
REQ-023 GAP: out_req=0 for exactly one cycle (L2 bus turnaround); then go to IDLE.
REQ-024 Latency: push at edge N into empty queue -> out_req=1 after edge N+1; back-to-back entries issue one request every 3 cycles minimum with out_ack tied high.
REQ-025 out_addr driven from the head register only, never bypassed from in_addr.
REQ-026 out_ack while not in REQ: ignored.

Reset
REQ-027 On rst: head=0, tail=0, count=0, FSM=IDLE, out_req=0, err_ovf=0, full=0; out_addr is undefined until first push.
REQ-028 Reset mid-request: outstanding request abandoned without pop; L2 discards partial transaction.
REQ-029 Entry storage is not cleared on reset.

Configuration
REQ-030 Macro DC1_WBQ_MERGE_EN defined: a push whose in_addr equals any occupied entry other than the head currently in REQ is dropped silently; no count change, no err_ovf, and it is accepted even when full.
REQ-031 DC1_WBQ_MERGE_EN undefined: no comparison; duplicate addresses enqueue as separate entries.

Verification
REQ-032 Reset, push 0x1_0000_0001 with in_valid=1, out_ack=1 -> out_req high one cycle after the push edge, out_addr=0x1_0000_0001, count 1->0, then one GAP cycle with out_req=0.
REQ-033 Push with in_en=1, in_valid=0 -> count stays 0, out_req stays 0.
REQ-034 out_ack=0, push 4 distinct addresses -> count=4, full=1; 5th push -> dropped, err_ovf=1, count=4; release ack -> the 4 addresses issue in push order.
REQ-035 count=4 in REQ, out_ack=1 and a push on the same edge -> full=0 that cycle, count stays 4, new address issued last.
REQ-036 Same address pushed twice behind a stalled head -> count=3 with DC1_WBQ_MERGE_EN, count=3 plus one duplicate (count=4) without.
REQ-037 rst asserted between clock edges while out_req=1 -> out_req=0, count=0 immediately, without waiting for a clock edge.
